as_wbd_arbiter: RTL and testbench

- Wishbone data-bus arbiter that shares the single data-bus slave side (address decoder, D-Mem BPI, GPIO, CGU, QSPI) between nr_masters bus masters.
- Master 0 is the CPU; master 1 is a debug/DMA master.
- Replaces the pass-through arbiter in as_top_mem: its s_cyc_o drives the decoder/slave strobes, and per-master ack/err replace the old gnt0-gated ack.
- Round-robin, transaction-granular grant with a stall watchdog.

---
 rtl/as_pack.sv | 9 +
 rtl/as_rr_pick.sv | 22 ++
 rtl/as_wbd_arbiter.sv | 111 +++++++++++
 tb/tb_as_wbd_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// as_pack: shared widths, defaults and arbiter state type for the data-bus fabric
package as_pack;
  localparam int daddr_width = 32;
  localparam int reg_width = 32;
  localparam int wbdSel = 4;
  localparam int nr_dmasters = 2;
  localparam int wbd_timeout = 255;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_ABORT} arb_state_t;
endpackage

// File: rtl/as_rr_pick.sv
// as_rr_pick: combinational round-robin picker, first requester after last_i wins
module as_rr_pick #(
  parameter int n = 2,
  parameter int pw = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]  req_i,
  input  logic [pw-1:0] last_i,
  output logic [n-1:0]  gnt_o,
  output logic          valid_o
);
  // farthest distance first, so the nearest requester overrides
  always_comb begin
    gnt_o = '0;
    for (int i = n; i > 0; i--)
      for (int k = 0; k < n; k++)
        if (req_i[k] && k == (int'(last_i) + i) % n) begin
          gnt_o = '0;
          gnt_o[k] = 1'b1;
        end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/as_wbd_arbiter.sv
// as_wbd_arbiter: round-robin, transaction-granular Wishbone data-bus arbiter with stall watchdog
module as_wbd_arbiter
  import as_pack::*;
#(
  parameter int nr_masters = nr_dmasters,
  parameter int addr_w = daddr_width,
  parameter int data_w = reg_width,
  parameter int sel_w = wbdSel,
  parameter int timeout_cycles = wbd_timeout
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [nr_masters-1:0]        m_cyc_i,
  input  logic [nr_masters-1:0]        m_stb_i,
  input  logic [nr_masters-1:0]        m_we_i,
  input  logic [nr_masters*sel_w-1:0]  m_sel_i,
  input  logic [nr_masters*addr_w-1:0] m_addr_i,
  input  logic [nr_masters*data_w-1:0] m_dat_i,
  output logic [data_w-1:0]            m_dat_o,
  output logic [nr_masters-1:0]        m_ack_o,
  output logic [nr_masters-1:0]        m_err_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [sel_w-1:0]             s_sel_o,
  output logic [addr_w-1:0]            s_addr_o,
  output logic [data_w-1:0]            s_dat_o,
  input  logic [data_w-1:0]            s_dat_i,
  input  logic                         s_ack_i,
  output logic [nr_masters-1:0]        gnt_o,
  output logic                         busy_o
);
  localparam int pw = $clog2(nr_masters);
  arb_state_t state_q, state_d;
  logic [nr_masters-1:0] gnt_q, gnt_d, err_q, err_d, pick_gnt;
  logic [pw-1:0] last_q, last_d, g_idx, ptr;
  logic [31:0] wd_q, wd_d;
  logic pick_valid, g_cyc, stall, timeout;
  always_comb begin
    g_idx = '0;
    g_cyc = 1'b0;
    for (int k = 0; k < nr_masters; k++)
      if (gnt_q[k]) begin
        g_idx = pw'(k);
        g_cyc = m_cyc_i[k];
      end
  end
  // on release the outgoing master becomes the pointer, so arbitration happens in the same clock
  assign ptr = (state_q == ARB_IDLE) ? last_q : g_idx;
  as_rr_pick #(.n(nr_masters), .pw(pw)) u_pick (
    .req_i(m_cyc_i),
    .last_i(ptr),
    .gnt_o(pick_gnt),
    .valid_o(pick_valid)
  );
  assign stall = s_stb_o & ~s_ack_i;
  assign timeout = (timeout_cycles != 0) && stall && wd_q == 32'(timeout_cycles - 1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      last_q <= pw'(nr_masters - 1);
      wd_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      wd_q <= wd_d;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    err_d = '0;
    wd_d = (state_q == ARB_GRANT && stall) ? wd_q + {31'd0, wd_q != '1} : '0;
    if (state_q == ARB_IDLE || !g_cyc) begin
      last_d = (state_q == ARB_IDLE) ? last_q : g_idx;
      state_d = pick_valid ? ARB_GRANT : ARB_IDLE;
      gnt_d = pick_gnt;
      wd_d = '0;
    end else if (state_q == ARB_GRANT && timeout) begin
      state_d = ARB_ABORT;
      err_d = gnt_q;
      wd_d = '0;
    end
  end
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o = 1'b0;
    s_sel_o = '0;
    s_addr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < nr_masters; k++)
      if (state_q == ARB_GRANT && gnt_q[k]) begin
        s_cyc_o = m_cyc_i[k];
        s_stb_o = m_cyc_i[k] & m_stb_i[k];
        s_we_o = m_we_i[k];
        s_sel_o = m_sel_i[k*sel_w +: sel_w];
        s_addr_o = m_addr_i[k*addr_w +: addr_w];
        s_dat_o = m_dat_i[k*data_w +: data_w];
      end
  end
  assign m_ack_o = gnt_q & {nr_masters{s_ack_i & s_cyc_o}};
  assign m_err_o = err_q;
  assign m_dat_o = s_dat_i;
  assign gnt_o = gnt_q;
  assign busy_o = state_q != ARB_IDLE;
endmodule

// File: tb/tb_as_wbd_arbiter.sv
// tb_as_wbd_arbiter: directed checks of grant order, routing, watchdog and reset
module tb_as_wbd_arbiter;
  localparam int n = 2, aw = 32, dw = 32, sw = 4;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic [n-1:0] m_cyc_i, m_stb_i, m_we_i;
  logic [n*sw-1:0] m_sel_i;
  logic [n*aw-1:0] m_addr_i;
  logic [n*dw-1:0] m_dat_i;
  logic [dw-1:0] s_dat_i;
  logic s_ack_i;
  logic [dw-1:0] a_m_dat_o, b_m_dat_o, a_s_dat_o, b_s_dat_o;
  logic [n-1:0] a_m_ack_o, b_m_ack_o, a_m_err_o, b_m_err_o, a_gnt_o, b_gnt_o;
  logic a_s_cyc_o, b_s_cyc_o, a_s_stb_o, b_s_stb_o, a_s_we_o, b_s_we_o, a_busy_o, b_busy_o;
  logic [sw-1:0] a_s_sel_o, b_s_sel_o;
  logic [aw-1:0] a_s_addr_o, b_s_addr_o;
  int total = 0, bad = 0;
  always #5 clk_i = ~clk_i;
  as_wbd_arbiter #(.nr_masters(n), .addr_w(aw), .data_w(dw), .sel_w(sw), .timeout_cycles(4)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_dat_o(a_m_dat_o),
    .m_ack_o(a_m_ack_o), .m_err_o(a_m_err_o), .s_cyc_o(a_s_cyc_o), .s_stb_o(a_s_stb_o),
    .s_we_o(a_s_we_o), .s_sel_o(a_s_sel_o), .s_addr_o(a_s_addr_o), .s_dat_o(a_s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(a_gnt_o), .busy_o(a_busy_o)
  );
  as_wbd_arbiter #(.nr_masters(n), .addr_w(aw), .data_w(dw), .sel_w(sw), .timeout_cycles(0)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_dat_o(b_m_dat_o),
    .m_ack_o(b_m_ack_o), .m_err_o(b_m_err_o), .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o),
    .s_we_o(b_s_we_o), .s_sel_o(b_s_sel_o), .s_addr_o(b_s_addr_o), .s_dat_o(b_s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(b_gnt_o), .busy_o(b_busy_o)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    int errs;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0; m_addr_i = '0; m_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0;
    step; step;
    chk("rst_gnt", a_gnt_o, 0); chk("rst_busy", a_busy_o, 0); chk("rst_scyc", a_s_cyc_o, 0);
    chk("rst_ack", a_m_ack_o, 0); chk("rst_err", a_m_err_o, 0);
    rst_i = 1'b1;
    step;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01; m_sel_i = 8'h3F;
    m_addr_i = {32'h0002_0000, 32'h0001_0000}; m_dat_i = {32'h0000_BBBB, 32'h0000_A5A5};
    #1 chk("t1_latency", a_s_cyc_o, 0);
    step;
    chk("t1_gnt", a_gnt_o, 2'b01); chk("t1_addr", a_s_addr_o, 32'h0001_0000);
    chk("t1_we", a_s_we_o, 1); chk("t1_dat", a_s_dat_o, 32'h0000_A5A5); chk("t1_sel", a_s_sel_o, 4'hF);
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
    #1 chk("t1_ack1", a_m_ack_o, 2'b01); chk("t1_rdat", a_m_dat_o, 32'hCAFE_0001);
    step;
    chk("t1_ack2", a_m_ack_o, 2'b01);
    step;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; s_ack_i = 1'b0;
    #1 chk("t1_noack", a_m_ack_o, 0);
    step;
    chk("t1_idle", a_busy_o, 0);
    s_ack_i = 1'b1;
    #1 chk("t1_stray_ack", a_m_ack_o, 0);
    s_ack_i = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step;
    chk("rr_idle_gnt", a_gnt_o, 2'b10); chk("rr_idle_addr", a_s_addr_o, 32'h0002_0000);
    rst_i = 1'b0;
    #1 chk("async_rst_gnt", a_gnt_o, 0);
    step;
    rst_i = 1'b1;
    step;
    chk("t2_first", a_gnt_o, 2'b01);
    s_ack_i = 1'b1;
    #1 chk("t2_ack0", a_m_ack_o, 2'b01);
    step;
    m_cyc_i = 2'b10; m_stb_i = 2'b10; s_ack_i = 1'b0;
    #1 chk("t2_hold", a_gnt_o, 2'b01); chk("t2_cyc_off", a_s_cyc_o, 0);
    step;
    chk("t2_switch", a_gnt_o, 2'b10); chk("t2_busy", a_busy_o, 1); chk("t2_addr", a_s_addr_o, 32'h0002_0000);
    s_ack_i = 1'b1; m_cyc_i = 2'b11; m_stb_i = 2'b11;
    #1 chk("t2_ack1", a_m_ack_o, 2'b10);
    step;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; s_ack_i = 1'b0;
    step;
    chk("t2_back", a_gnt_o, 2'b01);
    m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_gnt", a_gnt_o, 2'b01); chk("t3_ack", a_m_ack_o, 2'b01);
      step;
    end
    m_cyc_i = 2'b10; m_stb_i = 2'b10; s_ack_i = 1'b0;
    step;
    chk("t3_m1", a_gnt_o, 2'b10);
    rst_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    step;
    rst_i = 1'b1; m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step;
    chk("t4_gnt", a_gnt_o, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("t4_noerr", a_m_err_o, 0);
    end
    step;
    chk("t4_err", a_m_err_o, 2'b01); chk("t4_scyc", a_s_cyc_o, 0); chk("t4_b_noerr", b_m_err_o, 0);
    step;
    chk("t4_err_pulse", a_m_err_o, 0); chk("t4_abort_busy", a_busy_o, 1);
    step;
    s_ack_i = 1'b1;
    #1 chk("t4_late_ack", a_m_ack_o, 0);
    s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step;
    chk("t4_rearb", a_gnt_o, 2'b10);
    s_ack_i = 1'b1;
    #1 chk("t5_ack", a_m_ack_o, 2'b10);
    #2 rst_i = 1'b0;
    #1 chk("t5_gnt", a_gnt_o, 0); chk("t5_busy", a_busy_o, 0); chk("t5_scyc", a_s_cyc_o, 0);
    chk("t5_sstb", a_s_stb_o, 0); chk("t5_ack0", a_m_ack_o, 0); chk("t5_err0", a_m_err_o, 0);
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step;
    rst_i = 1'b1; s_ack_i = 1'b0;
    step;
    chk("t5_m0", a_gnt_o, 2'b01);
    rst_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    step;
    rst_i = 1'b1; m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      step;
      if (b_m_err_o != '0) errs++;
    end
    chk("t6_noerr", errs, 0); chk("t6_gnt", b_gnt_o, 2'b01);
    s_ack_i = 1'b1;
    #1 chk("t6_ack", b_m_ack_o, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
